sigmoid_arbiter: RTL

SIGMOID_ARBITER -- requirements
Module: sigmoid_arbiter

---
 rtl/sigmoid_pkg.sv | 20 ++
 rtl/sigmoid_arbiter_if.sv | 32 +++
 rtl/plan_sigmoid.sv | 53 +++++
 rtl/sigmoid_result_fifo.sv | 74 +++++++
 rtl/sigmoid_arbiter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/sigmoid_pkg.sv
`timescale 1ns/1ps
// Shared fixed-point constants and types for the sigmoid arbiter slice.
package sigmoid_pkg;

    localparam int          FRAC_BITS = 10;
    localparam logic [15:0] ONE_Q     = 16'd1024;

    // 16-bit fixed-point word, Q6.10 unsigned or Q5.10 signed by context
    typedef logic [15:0] fx_t;

    // Requester index (two requesters)
    typedef logic req_id_t;

    // One buffered result: owning requester plus corrected sigmoid value
    typedef struct packed {
        req_id_t id;
        fx_t     y;
    } result_t;

endpackage

// File: rtl/sigmoid_arbiter_if.sv
`timescale 1ns/1ps
// Request/response bundle between two requesters, one consumer and the arbiter.
interface sigmoid_arbiter_if
    import sigmoid_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) ();

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [1:0]       req_valid;
    fx_t  [1:0]       req_x;
    logic [1:0]       req_ready;
    logic             resp_valid;
    logic             resp_ready;
    req_id_t          resp_id;
    fx_t              resp_y;
    logic [CNT_W-1:0] outstanding;

    // Requesters and consumer side
    modport master (
        output req_valid, req_x, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_y, outstanding
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_x, resp_ready,
        output req_ready, resp_valid, resp_id, resp_y, outstanding
    );

endinterface

// File: rtl/plan_sigmoid.sv
`timescale 1ns/1ps
// PLAN piecewise-linear sigmoid of a non-negative Q6.10 operand, LAT-cycle pipeline.
module plan_sigmoid
    import sigmoid_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  fx_t  x,
    output fx_t  f_x
);

    localparam fx_t BRK_SAT = fx_t'(5 << FRAC_BITS);            // 5.0
    localparam fx_t BRK_MID = fx_t'(19 << (FRAC_BITS - 3));     // 2.375
    localparam fx_t BRK_LOW = fx_t'(1 << FRAC_BITS);            // 1.0
    localparam fx_t OFS_HI  = fx_t'(27 << (FRAC_BITS - 5));     // 0.84375
    localparam fx_t OFS_MID = fx_t'(5 << (FRAC_BITS - 3));      // 0.625
    localparam fx_t OFS_LOW = fx_t'(1 << (FRAC_BITS - 1));      // 0.5

    fx_t seg_y;
    fx_t pipe_d [LAT];
    fx_t pipe_q [LAT];

    // Segment selection: slopes 1/32, 1/8, 1/4 as shifts
    always_comb begin
        seg_y = ONE_Q;
        if (x >= BRK_SAT) begin
            seg_y = ONE_Q;
        end else if (x >= BRK_MID) begin
            seg_y = (x >> 5) + OFS_HI;
        end else if (x >= BRK_LOW) begin
            seg_y = (x >> 3) + OFS_MID;
        end else begin
            seg_y = (x >> 2) + OFS_LOW;
        end
    end

    // Delay line feeding the next stage
    always_comb begin
        pipe_d[0] = seg_y;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Datapath pipeline registers
    always_ff @(posedge clk) begin
        pipe_q <= pipe_d;
    end

    assign f_x = pipe_q[LAT-1];

endmodule

// File: rtl/sigmoid_result_fifo.sv
`timescale 1ns/1ps
// Show-ahead result FIFO; pointers wrap naturally because DEPTH is a power of two.
module sigmoid_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Empty FIFO presents zeros so the outputs are quiet during and after reset
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and storage
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed: reads are masked while empty
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sigmoid_arbiter.sv
`timescale 1ns/1ps
// Two-requester round-robin front end for plan_sigmoid with credit-checked result FIFO.
module sigmoid_arbiter
    import sigmoid_pkg::*;
#(
    parameter int SIG_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    sigmoid_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int RES_W = $bits(result_t);

    // Magnitude of a Q5.10 operand; -32768 wraps to 16'h8000, i.e. 32.0 unsigned
    function automatic fx_t abs_q(input logic signed [15:0] x);
        return x[15] ? fx_t'(-x) : fx_t'(x);
    endfunction

    // Clamp to 1.0 and mirror for negative operands: sigmoid(-x) = 1 - sigmoid(x)
    function automatic fx_t correct_y(input fx_t f, input logic neg);
        fx_t fc;
        fc = (f > ONE_Q) ? ONE_Q : f;
        return neg ? (ONE_Q - fc) : fc;
    endfunction

    logic [1:0]         grant;
    req_id_t            grant_id;
    logic               xfer;
    logic               pop;
    logic               fifo_empty;
    logic signed [15:0] x_sel_s;

    req_id_t            rr_last_d, rr_last_q;
    logic [CNT_W-1:0]   outstanding_d, outstanding_q;

    logic               issue_vld_p0_d, issue_vld_p0_q;
    fx_t                issue_x_p0_d, issue_x_p0_q;
    logic               issue_neg_p0_d, issue_neg_p0_q;
    req_id_t            issue_id_p0_d, issue_id_p0_q;

    logic               sb_vld_d [SIG_LAT];
    logic               sb_vld_q [SIG_LAT];
    logic               sb_neg_d [SIG_LAT];
    logic               sb_neg_q [SIG_LAT];
    req_id_t            sb_id_d  [SIG_LAT];
    req_id_t            sb_id_q  [SIG_LAT];

    fx_t                f_x;
    logic               exit_vld;
    result_t            exit_res;
    result_t            head;

    // Grant from request strobes and registered credit/pointer only; never from resp_ready
    always_comb begin
        grant = 2'b00;
        if (reset_n && (outstanding_q < CNT_W'(FIFO_DEPTH))) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign grant_id      = grant[1];
    assign xfer          = |(bus.req_valid & grant);
    assign x_sel_s       = $signed(bus.req_x[grant_id]);
    assign pop           = !fifo_empty && bus.resp_ready;

    // Next-state for arbitration pointer, credit counter and issue register
    always_comb begin
        rr_last_d      = rr_last_q;
        outstanding_d  = outstanding_q;
        issue_vld_p0_d = xfer;
        issue_x_p0_d   = issue_x_p0_q;
        issue_neg_p0_d = issue_neg_p0_q;
        issue_id_p0_d  = issue_id_p0_q;
        if (xfer) begin
            rr_last_d      = grant_id;
            issue_x_p0_d   = abs_q(x_sel_s);
            issue_neg_p0_d = x_sel_s[15];
            issue_id_p0_d  = grant_id;
        end
        if (xfer && !pop) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!xfer && pop) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    // ---- stage p0 -> p1..pSIG_LAT: sideband follows the operand through plan_sigmoid
    always_comb begin
        sb_vld_d[0] = issue_vld_p0_q;
        sb_neg_d[0] = issue_neg_p0_q;
        sb_id_d[0]  = issue_id_p0_q;
        for (int i = 1; i < SIG_LAT; i++) begin
            sb_vld_d[i] = sb_vld_q[i-1];
            sb_neg_d[i] = sb_neg_q[i-1];
            sb_id_d[i]  = sb_id_q[i-1];
        end
    end

    // Control and issue state with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last_q      <= 1'b1;
            outstanding_q  <= '0;
            issue_vld_p0_q <= 1'b0;
            issue_x_p0_q   <= '0;
            issue_neg_p0_q <= 1'b0;
            issue_id_p0_q  <= '0;
            sb_vld_q       <= '{default: 1'b0};
            sb_neg_q       <= '{default: 1'b0};
            sb_id_q        <= '{default: '0};
        end else begin
            rr_last_q      <= rr_last_d;
            outstanding_q  <= outstanding_d;
            issue_vld_p0_q <= issue_vld_p0_d;
            issue_x_p0_q   <= issue_x_p0_d;
            issue_neg_p0_q <= issue_neg_p0_d;
            issue_id_p0_q  <= issue_id_p0_d;
            sb_vld_q       <= sb_vld_d;
            sb_neg_q       <= sb_neg_d;
            sb_id_q        <= sb_id_d;
        end
    end

    plan_sigmoid #(
        .LAT (SIG_LAT)
    ) u_plan (
        .x   (issue_x_p0_q),
        .clk (clk),
        .f_x (f_x)
    );

    // ---- pipeline exit: correct and push into the result FIFO
    assign exit_vld    = sb_vld_q[SIG_LAT-1];
    assign exit_res.id = sb_id_q[SIG_LAT-1];
    assign exit_res.y  = correct_y(f_x, sb_neg_q[SIG_LAT-1]);

    sigmoid_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RES_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (exit_vld),
        .wr_data (exit_res),
        .pop     (pop),
        .empty   (fifo_empty),
        .rd_data (head)
    );

    assign bus.resp_valid  = !fifo_empty;
    assign bus.resp_id     = head.id;
    assign bus.resp_y      = head.y;
    assign bus.outstanding = outstanding_q;

endmodule
